conv_deinterleaver: RTL

Forney convolutional deinterleaver (I=12, M=17) for the DVB-C receive path, and the receive-side inverse of the transmit-chain interleaver. It sits after symbol-to-byte demapping and the packet sync detector, and ahead of the RS decoder. It realigns the byte commutator on each packet sync and reports lock once the delay lines hold valid data. Every byte leaves with the same end-to-end interleave and deinterleave delay of I·(I−1)·M = 2244 valid bytes, which is 11 whole packets.

---
 rtl/dvbc_pkg.sv | 28 ++
 rtl/conv_deinterleaver_ram.sv | 29 ++
 rtl/conv_deinterleaver.sv | 123 ++++++++++++
 3 files changed

// File: rtl/dvbc_pkg.sv
// Shared constants, branch segment geometry and FSM state type for the
// DVB-C convolutional deinterleaver (I=12, M=17).
package dvbc_pkg;

    localparam int unsigned I         = 12;
    localparam int unsigned M         = 17;
    localparam int unsigned PKT_LEN   = I * M;
    localparam int unsigned DLY_TOTAL = I * (I - 1) * M;
    localparam int unsigned RAM_DEPTH = M * I * (I - 1) / 2;

    localparam int unsigned BW = $clog2(I);
    localparam int unsigned NW = $clog2(PKT_LEN);
    localparam int unsigned FW = $clog2(DLY_TOTAL + 1);
    localparam int unsigned AW = $clog2(RAM_DEPTH);
    localparam int unsigned PW = $clog2((I - 1) * M);

    typedef enum logic [1:0] {HUNT, FILL, LOCK} state_t;

    function automatic int unsigned seg_len(input int unsigned j);
        return (I - 1 - j) * M;
    endfunction

    // Closed form of M * sum_{k<j} (I-1-k)
    function automatic int unsigned seg_base(input int unsigned j);
        return M * (j * (2 * I - 1 - j) / 2);
    endfunction

endpackage

// File: rtl/conv_deinterleaver_ram.sv
// Single-clock byte RAM backing the deinterleaver delay lines; a read during
// a write to the same cell returns the old contents.
module deintRam
    import dvbc_pkg::*;
#(
    parameter int unsigned DW     = 8,
    parameter int unsigned DEPTH  = RAM_DEPTH,
    parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              en,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DW-1:0]     wr_data,
    output logic [DW-1:0]     rd_data
);

    logic [DW-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (en) begin
            rd_data <= mem[addr];
            if (we) begin
                mem[addr] <= wr_data;
            end
        end
    end

endmodule

// File: rtl/conv_deinterleaver.sv
// Forney convolutional deinterleaver: per-branch circular delay lines in one
// RAM, commutator realigned on packet sync, lock once the lines are refilled.
module conv_deinterleaver
    import dvbc_pkg::*;
#(
    parameter int unsigned DW = 8
) (
    input  logic          iClk,
    input  logic          iClrn,
    input  logic          iValid,
    input  logic [DW-1:0] iData,
    input  logic          iPSync,
    output logic [DW-1:0] oData,
    output logic          oValid,
    output logic          oPSync,
    output logic          oLock
);

    localparam int unsigned NB = I - 1;

    state_t        state, state_nxt;
    logic [BW-1:0] b, b_cur, b_q;
    logic [NW-1:0] n, n_cur;
    logic [FW-1:0] f;
    logic [PW-1:0] ptr [NB];
    logic          align, lock_nxt, we;
    logic [AW-1:0] addr;
    logic [DW-1:0] rd_data, pass_q;

    always_comb begin
        align     = iValid && iPSync && (state == HUNT || b != '0 || n != '0);
        b_cur     = align ? '0 : b;
        n_cur     = align ? '0 : n;
        state_nxt = state;
        if (align) begin
            state_nxt = FILL;
        end else if (iValid && state == FILL && f == FW'(DLY_TOTAL - 1)) begin
            state_nxt = LOCK;
        end
        lock_nxt  = (state_nxt == LOCK);
    end

    always_comb begin
        addr = '0;
        for (int unsigned j = 0; j < NB; j++) begin
            if (b_cur == BW'(j)) begin
                addr = AW'(seg_base(j)) + AW'(ptr[j]);
            end
        end
    end

    assign we = iValid && !iClrn && (b_cur != BW'(I - 1));

    always_ff @(posedge iClk) begin
        if (iClrn) begin
            state <= HUNT;
            b     <= '0;
            n     <= '0;
            f     <= '0;
        end else begin
            state <= state_nxt;
            if (iValid) begin
                b <= (b_cur == BW'(I - 1)) ? '0 : b_cur + 1'b1;
                n <= (n_cur == NW'(PKT_LEN - 1)) ? '0 : n_cur + 1'b1;
                if (align) begin
                    f <= FW'(1);
                end else if (state == FILL) begin
                    f <= f + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge iClk) begin
        if (iClrn) begin
            for (int unsigned j = 0; j < NB; j++) begin
                ptr[j] <= '0;
            end
        end else if (we) begin
            for (int unsigned j = 0; j < NB; j++) begin
                if (b_cur == BW'(j)) begin
                    ptr[j] <= (ptr[j] == PW'(seg_len(j) - 1)) ? '0 : ptr[j] + 1'b1;
                end
            end
        end
    end

    // Reset parks the output mux on the pass-through register so oData reads
    // zero even though the RAM itself is never cleared.
    always_ff @(posedge iClk) begin
        if (iClrn) begin
            oValid <= 1'b0;
            oPSync <= 1'b0;
            oLock  <= 1'b0;
            b_q    <= BW'(I - 1);
            pass_q <= '0;
        end else begin
            oValid <= iValid && lock_nxt;
            oPSync <= iValid && lock_nxt && (n_cur == '0);
            oLock  <= lock_nxt;
            if (iValid) begin
                b_q    <= b_cur;
                pass_q <= iData;
            end
        end
    end

    assign oData = (b_q == BW'(I - 1)) ? pass_q : rd_data;

    deintRam #(
        .DW     (DW),
        .DEPTH  (RAM_DEPTH),
        .ADDR_W (AW)
    ) u_ram (
        .clk     (iClk),
        .en      (iValid && !iClrn),
        .we      (we),
        .addr    (addr),
        .wr_data (iData),
        .rd_data (rd_data)
    );

endmodule
